// File: rtl/mux2_mux3_inputs.sv
// rtl/mux2_mux3_inputs.sv - paired 2-input and 3-input decode-stage datapath selectors
module mux2_mux3_inputs #(
  parameter int WIDTH        = 32,
  parameter int REGISTERED   = 0,
  parameter int SEL3_DEFAULT = 0
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             En,
  input  logic [WIDTH-1:0] m2_in0,
  input  logic [WIDTH-1:0] m2_in1,
  input  logic             m2_sel,
  output logic [WIDTH-1:0] m2_out,
  input  logic [WIDTH-1:0] m3_in0,
  input  logic [WIDTH-1:0] m3_in1,
  input  logic [WIDTH-1:0] m3_in2,
  input  logic [1:0]       m3_sel,
  output logic [WIDTH-1:0] m3_out,
  output logic             m3_sel_err
);

  logic [WIDTH-1:0] m2_next;
  logic [WIDTH-1:0] m3_next;
  logic             err_next;

  // Next-PC source: branch target or jump/jr target
  always_comb begin
    m2_next = m2_in0;
    case (m2_sel)
      1'b0:    m2_next = m2_in0;
      1'b1:    m2_next = m2_in1;
      default: m2_next = m2_in0;
    endcase
  end

  // Comparator/jr operand: regfile, EX/MEM forward or MEM/WB forward; 2'b11 is a decode fault
  always_comb begin
    m3_next  = m3_in0;
    err_next = 1'b0;
    case (m3_sel)
      2'b00: m3_next = m3_in0;
      2'b01: m3_next = m3_in1;
      2'b10: m3_next = m3_in2;
      2'b11: begin
        m3_next  = (SEL3_DEFAULT == 0) ? m3_in0 : '0;
        err_next = 1'b1;
      end
      default: begin
        m3_next  = m3_in0;
        err_next = 1'b0;
      end
    endcase
  end

  generate
    if (REGISTERED != 0) begin : g_reg
      // Output stage: async clear, loads only on enabled edges
      always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
          m2_out     <= '0;
          m3_out     <= '0;
          m3_sel_err <= 1'b0;
        end else if (En) begin
          m2_out     <= m2_next;
          m3_out     <= m3_next;
          m3_sel_err <= err_next;
        end
      end
    end else begin : g_comb
      // Clock, reset and enable play no part in the zero-latency build
      logic unused_ctrl;
      assign unused_ctrl = &{1'b0, Clk, Rst_n, En};
      assign m2_out      = m2_next;
      assign m3_out      = m3_next;
      assign m3_sel_err  = err_next;
    end
  endgenerate

endmodule

// File: tb/tb_mux2_mux3_inputs.sv
// tb/tb_mux2_mux3_inputs.sv - scoreboard bench for combinational and registered selector builds
module tb_mux2_mux3_inputs;
  localparam int W = 32;

  typedef struct packed {
    logic [W-1:0] m2;
    logic [W-1:0] m3;
    logic         err;
  } exp_t;

  typedef struct packed {
    exp_t c0;
    exp_t c1;
    exp_t r0;
    exp_t r1;
  } exp4_t;

  logic         Clk = 1'b0;
  logic         Rst_n;
  logic         En;
  logic         m2_sel;
  logic [1:0]   m3_sel;
  logic [W-1:0] m2_in0, m2_in1, m3_in0, m3_in1, m3_in2;
  logic [W-1:0] m2o [4];
  logic [W-1:0] m3o [4];
  logic         erro [4];

  int    checks = 0;
  int    errors = 0;
  exp4_t sbq[$];
  exp_t  reg_m [2];

  always #5 Clk = ~Clk;

  mux2_mux3_inputs #(.WIDTH(W), .REGISTERED(0), .SEL3_DEFAULT(0)) u_c0 (
    .Clk(Clk), .Rst_n(Rst_n), .En(En), .m2_in0(m2_in0), .m2_in1(m2_in1), .m2_sel(m2_sel),
    .m2_out(m2o[0]), .m3_in0(m3_in0), .m3_in1(m3_in1), .m3_in2(m3_in2), .m3_sel(m3_sel),
    .m3_out(m3o[0]), .m3_sel_err(erro[0]));
  mux2_mux3_inputs #(.WIDTH(W), .REGISTERED(0), .SEL3_DEFAULT(1)) u_c1 (
    .Clk(Clk), .Rst_n(Rst_n), .En(En), .m2_in0(m2_in0), .m2_in1(m2_in1), .m2_sel(m2_sel),
    .m2_out(m2o[1]), .m3_in0(m3_in0), .m3_in1(m3_in1), .m3_in2(m3_in2), .m3_sel(m3_sel),
    .m3_out(m3o[1]), .m3_sel_err(erro[1]));
  mux2_mux3_inputs #(.WIDTH(W), .REGISTERED(1), .SEL3_DEFAULT(0)) u_r0 (
    .Clk(Clk), .Rst_n(Rst_n), .En(En), .m2_in0(m2_in0), .m2_in1(m2_in1), .m2_sel(m2_sel),
    .m2_out(m2o[2]), .m3_in0(m3_in0), .m3_in1(m3_in1), .m3_in2(m3_in2), .m3_sel(m3_sel),
    .m3_out(m3o[2]), .m3_sel_err(erro[2]));
  mux2_mux3_inputs #(.WIDTH(W), .REGISTERED(1), .SEL3_DEFAULT(1)) u_r1 (
    .Clk(Clk), .Rst_n(Rst_n), .En(En), .m2_in0(m2_in0), .m2_in1(m2_in1), .m2_sel(m2_sel),
    .m2_out(m2o[3]), .m3_in0(m3_in0), .m3_in1(m3_in1), .m3_in2(m3_in2), .m3_sel(m3_sel),
    .m3_out(m3o[3]), .m3_sel_err(erro[3]));

  // Reference: pick an entry from a table of candidates indexed by the select
  function automatic exp_t model(input bit zero_on3);
    logic [W-1:0] opt2 [2];
    logic [W-1:0] opt3 [4];
    exp_t r;
    opt2[0] = m2_in0;
    opt2[1] = m2_in1;
    opt3[0] = m3_in0;
    opt3[1] = m3_in1;
    opt3[2] = m3_in2;
    opt3[3] = zero_on3 ? '0 : m3_in0;
    r.m2  = opt2[m2_sel];
    r.m3  = opt3[m3_sel];
    r.err = (m3_sel == 2'd3);
    return r;
  endfunction

  function automatic exp_t dut_out(input int i);
    exp_t r;
    r.m2  = m2o[i];
    r.m3  = m3o[i];
    r.err = erro[i];
    return r;
  endfunction

  task automatic check(input string nm, input exp_t act, input exp_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got m2=%h m3=%h err=%b, expected m2=%h m3=%h err=%b",
               nm, act.m2, act.m3, act.err, exp.m2, exp.m3, exp.err);
    end
  endtask

  // One stimulus cycle, applied just after the rising edge; expectations go to the scoreboard
  task automatic drive(input logic rn, input logic en_i, input logic s2, input logic [1:0] s3,
                       input logic [W-1:0] a2, input logic [W-1:0] b2,
                       input logic [W-1:0] a3, input logic [W-1:0] b3, input logic [W-1:0] c3);
    exp4_t e;
    @(posedge Clk);
    #1;
    if (!Rst_n) begin
      reg_m[0] = '0;
      reg_m[1] = '0;
    end else if (En) begin
      reg_m[0] = model(1'b0);
      reg_m[1] = model(1'b1);
    end
    Rst_n = rn; En = en_i; m2_sel = s2; m3_sel = s3;
    m2_in0 = a2; m2_in1 = b2; m3_in0 = a3; m3_in1 = b3; m3_in2 = c3;
    if (!rn) begin
      reg_m[0] = '0;
      reg_m[1] = '0;
    end
    e.c0 = model(1'b0);
    e.c1 = model(1'b1);
    e.r0 = reg_m[0];
    e.r1 = reg_m[1];
    sbq.push_back(e);
  endtask

  // Monitor: compare every DUT against the oldest pending expectation at the falling edge
  always @(negedge Clk) begin
    if (sbq.size() > 0) begin
      exp4_t e;
      e = sbq.pop_front();
      check("comb_d0", dut_out(0), e.c0);
      check("comb_d1", dut_out(1), e.c1);
      check("reg_d0",  dut_out(2), e.r0);
      check("reg_d1",  dut_out(3), e.r1);
    end
  end

  initial begin
    exp_t zero;
    zero = '0;
    reg_m[0] = '0;
    reg_m[1] = '0;
    Rst_n = 1'b0; En = 1'b0; m2_sel = 1'b0; m3_sel = 2'd0;
    m2_in0 = '0; m2_in1 = '0; m3_in0 = '0; m3_in1 = '0; m3_in2 = '0;

    drive(1'b0, 1'b1, 1'b0, 2'd0, 32'h0000_0040, 32'h0040_0000, 32'd10, 32'd20, 32'd30);
    drive(1'b0, 1'b1, 1'b1, 2'd1, 32'h0000_0040, 32'h0040_0000, 32'd10, 32'd20, 32'd30);

    // Select sweeps on both muxes
    drive(1'b1, 1'b1, 1'b0, 2'd0, 32'h0000_0040, 32'h0040_0000, 32'd10, 32'd20, 32'd30);
    drive(1'b1, 1'b1, 1'b1, 2'd1, 32'h0000_0040, 32'h0040_0000, 32'd10, 32'd20, 32'd30);
    drive(1'b1, 1'b1, 1'b0, 2'd2, 32'h0000_0040, 32'h0040_0000, 32'd10, 32'd20, 32'd30);
    drive(1'b1, 1'b1, 1'b1, 2'd3, 32'h0000_0040, 32'h0040_0000, 32'd10, 32'd20, 32'd30);
    drive(1'b1, 1'b1, 1'b0, 2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

    // Registered load, then hold with En low
    drive(1'b1, 1'b1, 1'b0, 2'd2, 32'h0000_0001, 32'h0000_0002, 32'h1111_1111, 32'h2222_2222, 32'hDEAD_BEEF);
    drive(1'b1, 1'b0, 1'b1, 2'd1, 32'h0000_0003, 32'h0000_0004, 32'h3333_3333, 32'h4444_4444, 32'h5555_5555);
    drive(1'b1, 1'b0, 1'b0, 2'd1, 32'h0000_0005, 32'h0000_0006, 32'h6666_6666, 32'h7777_7777, 32'h8888_8888);

    // Reset dropped between edges clears registered outputs at once
    drive(1'b0, 1'b1, 1'b1, 2'd2, 32'h0000_0007, 32'h0000_0008, 32'h9999_9999, 32'hAAAA_AAAA, 32'hBBBB_BBBB);
    #1;
    check("reg_d0_async_rst", dut_out(2), zero);
    check("reg_d1_async_rst", dut_out(3), zero);
    drive(1'b1, 1'b1, 1'b1, 2'd0, 32'h0000_0000, 32'h0000_1234, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000);
    drive(1'b1, 1'b0, 1'b0, 2'd1, 32'h0000_00AA, 32'h0000_00BB, 32'h0000_00CC, 32'h0000_00DD, 32'h0000_00EE);

    // Random traffic with occasional resets and enable gaps
    for (int i = 0; i < 1000; i++) begin
      drive(($urandom_range(63) != 0), 1'($urandom_range(1)), 1'($urandom_range(1)),
            2'($urandom_range(3)), $urandom, $urandom, $urandom, $urandom, $urandom);
    end

    repeat (3) @(negedge Clk);
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", sbq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
